// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one UART transmitter from two requesters,
// with per-frame retransmission on uncorrectable error or receive timeout.
module uart_tx_arbiter #(
    parameter int MAX_RETRY   = 2,
    parameter int TIMEOUT_CYC = 4095
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [7:0]  req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [7:0]  req1_data,
    output logic        req1_ready,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_busy,
    input  logic        rx_done,
    input  logic        rx_double_err,
    input  logic        rx_corrected,
    output logic        grant_id,
    output logic        drop_pulse,
    output logic [15:0] sent_count,
    output logic [15:0] corrected_count
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE
    } state_t;

    localparam logic [2:0]  RETRY_MAX = 3'(MAX_RETRY);
    localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYC - 1);

    state_t      state_q;
    logic        ptr_q;
    logic        grant_q;
    logic        drop_q;
    logic [7:0]  held_q;
    logic [2:0]  retry_q;
    logic [15:0] tmo_q;
    logic [15:0] sent_q;
    logic [15:0] corr_q;

    logic pick_d;
    logic accept_d;
    logic timeout_hit;

    // pick_d = 1 selects requester 1; the pointer only matters on contention
    assign pick_d      = (req0_valid && req1_valid) ? ptr_q : req1_valid;
    assign accept_d    = !rst && (state_q == IDLE) && (req0_valid || req1_valid);
    assign timeout_hit = (tmo_q == TMO_LAST);

    assign req0_ready      = accept_d && !pick_d;
    assign req1_ready      = accept_d && pick_d;
    assign tx_start        = (state_q == ISSUE) && !tx_busy;
    assign tx_data         = held_q;
    assign grant_id        = grant_q;
    assign drop_pulse      = drop_q;
    assign sent_count      = sent_q;
    assign corrected_count = corr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            grant_q <= 1'b0;
            drop_q  <= 1'b0;
            held_q  <= 8'h00;
            retry_q <= 3'd0;
            tmo_q   <= 16'd0;
            sent_q  <= 16'd0;
            corr_q  <= 16'd0;
        end else begin
            drop_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept_d) begin
                        held_q  <= pick_d ? req1_data : req0_data;
                        grant_q <= pick_d;
                        ptr_q   <= ~pick_d;
                        retry_q <= 3'd0;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!tx_busy) begin
                        tmo_q   <= 16'd0;
                        state_q <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    tmo_q <= tmo_q + 16'd1;
                    // a receive report wins over a coincident timeout
                    if (rx_done && !rx_double_err) begin
                        if (sent_q != 16'hFFFF) sent_q <= sent_q + 16'd1;
                        if (rx_corrected && (corr_q != 16'hFFFF)) corr_q <= corr_q + 16'd1;
                        state_q <= IDLE;
                    end else if (rx_done || timeout_hit) begin
                        if (retry_q < RETRY_MAX) begin
                            retry_q <= retry_q + 3'd1;
                            state_q <= ISSUE;
                        end else begin
                            drop_q  <= 1'b1;
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized frames,
// scored against a frame-level model of arbitration, retries and counters.
module tb_uart_tx_arbiter;

    localparam int MAXR = 2;
    localparam int TMO  = 50;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic [7:0]  req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic        rx_done, rx_double_err, rx_corrected;
    logic        grant_id;
    logic        drop_pulse;
    logic [15:0] sent_count, corrected_count;

    int checks = 0;
    int errors = 0;

    bit ptr_m;
    int exp_sent;
    int exp_corr;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.MAX_RETRY(MAXR), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
        .rx_done(rx_done), .rx_double_err(rx_double_err), .rx_corrected(rx_corrected),
        .grant_id(grant_id), .drop_pulse(drop_pulse),
        .sent_count(sent_count), .corrected_count(corrected_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called in the first ISSUE cycle; holds tx_busy for 'busy' cycles first.
    task automatic attempt(input logic [7:0] b, input bit gid, input int busy);
        for (int i = 0; i < busy; i++) begin
            rx_done       = 1'b1;
            rx_double_err = 1'($urandom_range(0, 1));
            rx_corrected  = 1'($urandom_range(0, 1));
            #1 chk("tx_start_while_busy", tx_start, 0);
            req0_data = 8'($urandom);
            req1_data = 8'($urandom);
            step();
        end
        rx_done = 1'b0; rx_double_err = 1'b0; rx_corrected = 1'b0;
        tx_busy = 1'b0;
        #1;
        chk("tx_start", tx_start, 1);
        chk("tx_data", tx_data, b);
        chk("grant_id", grant_id, gid);
    endtask

    // kind: 0 clean rx, 1 double-error rx, 2 no rx (timeout)
    task automatic resolve(input int kind, input int delay, input bit corr, input bit next_busy);
        if (kind == 2) begin
            for (int i = 1; i <= TMO; i++) begin
                step();
                if (i == TMO) begin
                    #1 chk("no_early_timeout", tx_start, 0);
                end
            end
            tx_busy = next_busy;
            step();
        end else begin
            repeat (delay) step();
            rx_done       = 1'b1;
            rx_double_err = (kind == 1);
            rx_corrected  = corr;
            tx_busy       = next_busy;
            step();
            rx_done = 1'b0; rx_double_err = 1'b0; rx_corrected = 1'b0;
        end
    endtask

    // fmode: 1 double error, 2 timeout, 3 random per failure
    task automatic run_frame(input bit v0, input bit v1, input logic [7:0] d0, input logic [7:0] d1,
                             input int nfail, input int fmode, input bit corr,
                             input int busy0, input int delay, output bit w);
        logic [7:0] b;
        int kind;
        int bz;
        w = (v0 && v1) ? ptr_m : v1;
        b = w ? d1 : d0;
        req0_valid = v0; req1_valid = v1;
        req0_data = d0;  req1_data = d1;
        tx_busy = (busy0 > 0);
        #1;
        chk("req0_ready", req0_ready, v0 && !w);
        chk("req1_ready", req1_ready, v1 && w);
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        ptr_m = ~w;
        bz = busy0;
        for (int a = 0; a <= MAXR; a++) begin
            attempt(b, w, bz);
            bz = $urandom_range(0, 2);
            if (a < nfail) begin
                kind = (fmode == 3) ? $urandom_range(1, 2) : fmode;
                resolve(kind, delay, 1'b0, (a < MAXR) && (bz > 0));
                if (a == MAXR) begin
                    #1;
                    chk("drop_pulse", drop_pulse, 1);
                    chk("sent_after_drop", sent_count, exp_sent);
                    chk("corr_after_drop", corrected_count, exp_corr);
                    step();
                    #1 chk("drop_one_cycle", drop_pulse, 0);
                end
            end else begin
                resolve(0, delay, corr, 1'b0);
                if (exp_sent != 65535) exp_sent++;
                if (corr && exp_corr != 65535) exp_corr++;
                #1;
                chk("no_drop_on_success", drop_pulse, 0);
                chk("sent_count", sent_count, exp_sent);
                chk("corrected_count", corrected_count, exp_corr);
                break;
            end
        end
    endtask

    initial begin
        bit w;
        bit [3:0] seq;
        int r;
        rst = 1'b1;
        req0_valid = 0; req1_valid = 0; req0_data = 0; req1_data = 0;
        tx_busy = 0; rx_done = 0; rx_double_err = 0; rx_corrected = 0;
        step(); step();
        #1;
        chk("rst_tx_start", tx_start, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_drop", drop_pulse, 0);
        chk("rst_sent", sent_count, 0);
        chk("rst_corr", corrected_count, 0);
        step();
        rst = 1'b0;
        ptr_m = 1'b0; exp_sent = 0; exp_corr = 0;

        run_frame(1, 0, 8'hA5, 8'h00, 0, 1, 0, 0, 20, w);
        chk("single_frame_sent", sent_count, 1);

        // clean rx_done coinciding with the timeout cycle must count as success
        run_frame(0, 1, 8'h00, 8'h5C, 0, 1, 0, 0, TMO, w);

        for (int i = 0; i < 4; i++) begin
            run_frame(1, 1, 8'h11, 8'h22, 0, 1, 0, 0, 5, w);
            seq[i] = w;
        end
        chk("rr_sequence", 32'(seq), 32'h0000_000A);

        run_frame(1, 0, 8'h3C, 8'h00, 3, 1, 0, 0, 7, w);
        run_frame(0, 1, 8'h00, 8'hC3, 3, 2, 0, 0, 1, w);
        run_frame(1, 0, 8'h5A, 8'h00, 0, 1, 1, 3, 12, w);
        run_frame(1, 1, 8'h66, 8'h99, 1, 1, 0, 2, 9, w);
        run_frame(1, 1, 8'h67, 8'h98, 2, 2, 1, 1, 3, w);

        repeat (25) begin
            r = $urandom_range(1, 3);
            run_frame(r[0], r[1], 8'($urandom), 8'($urandom), $urandom_range(0, 3), 3,
                      1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(1, TMO), w);
        end

        // reset while a frame is waiting for its receive report
        req0_valid = 1'b1; req0_data = 8'hE1;
        step();
        req0_valid = 1'b0;
        step();
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("ready0_in_wait", req0_ready, 0);
        chk("ready1_in_wait", req1_ready, 0);
        rst = 1'b1;
        #1;
        chk("async_rst_ready0", req0_ready, 0);
        chk("async_rst_ready1", req1_ready, 0);
        chk("async_rst_tx_start", tx_start, 0);
        chk("async_rst_tx_data", tx_data, 0);
        chk("async_rst_grant", grant_id, 0);
        chk("async_rst_drop", drop_pulse, 0);
        chk("async_rst_sent", sent_count, 0);
        chk("async_rst_corr", corrected_count, 0);
        step();
        #1 chk("no_drop_after_rst", drop_pulse, 0);
        step();
        rst = 1'b0;
        ptr_m = 1'b0; exp_sent = 0; exp_corr = 0;
        run_frame(1, 1, 8'h77, 8'h88, 0, 1, 0, 0, 5, w);
        chk("post_rst_winner", 32'(w), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
